// File: rtl/frame_hdr_insert_pkg.sv
// frame_hdr_pkg: shared FSM state type and header constants for frame_hdr_insert
package frame_hdr_pkg;
  typedef enum logic [1:0] {IDLE, HDR1, PAYLOAD} frame_hdr_state_t;
  localparam logic [15:0] FRAME_HDR_SYNC_DEFAULT = 16'hA5C3;
  localparam int FRAME_HDR_WORDS = 2;
endpackage

// File: rtl/frame_hdr_insert_if.sv
// frame_hdr_insert_if: 32-bit AXI4-Stream bundle (tdata/tkeep/tlast/tvalid/tready)
//   master: drives tdata, tkeep, tlast, tvalid; receives tready
//   slave : receives tdata, tkeep, tlast, tvalid; drives tready
interface frame_hdr_insert_if;
  logic [31:0] tdata;
  logic [3:0] tkeep;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/frame_hdr_insert_axis_out_reg.sv
// axis_out_reg: single AXI4-Stream output register stage
//   clk, areset : clock, asynchronous active-high reset
//   in_*        : candidate beat, captured whenever load is high
//   load        : register may take a new beat (empty or being drained)
//   m           : registered downstream stream, held stable while stalled
module axis_out_reg (
  input  logic clk,
  input  logic areset,
  input  logic in_valid,
  input  logic [31:0] in_data,
  input  logic [3:0] in_keep,
  input  logic in_last,
  output logic load,
  frame_hdr_insert_if.master m
);
  assign load = !m.tvalid || m.tready;
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      m.tvalid <= 1'b0;
      m.tdata <= '0;
      m.tkeep <= '0;
      m.tlast <= 1'b0;
    end else if (load) begin
      m.tvalid <= in_valid;
      m.tdata <= in_data;
      m.tkeep <= in_keep;
      m.tlast <= in_last;
    end
  end
endmodule

// File: rtl/frame_hdr_insert.sv
// frame_hdr_insert: prepends {sync,seq} and timestamp header words to each AXI4-Stream frame
//   clk, areset  : stream clock, asynchronous active-high reset
//   hdr_en       : 1 = insert header, 0 = pass-through (sampled in IDLE)
//   max_len      : max payload beats minus 1 (only with FRAME_HDR_LEN_CHECK_EN)
//   s, m         : upstream / downstream stream
//   frame_count  : frames completed on the downstream side
//   trunc_count  : frames cut by the length check (0 without FRAME_HDR_LEN_CHECK_EN)
// Optional feature macro: FRAME_HDR_LEN_CHECK_EN
module frame_hdr_insert
  import frame_hdr_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = FRAME_HDR_SYNC_DEFAULT,
  parameter int TS_W = 32
) (
  input  logic clk,
  input  logic areset,
  input  logic hdr_en,
  input  logic [31:0] max_len,
  frame_hdr_insert_if.slave s,
  frame_hdr_insert_if.master m,
  output logic [31:0] frame_count,
  output logic [15:0] trunc_count
);
  frame_hdr_state_t state, state_nxt;
  logic [15:0] seq;
  logic [TS_W-1:0] ts, ts_lat;
  logic hdr_cur;
  logic load, out_valid, out_last, seq_inc;
  logic [31:0] out_data;
  logic [3:0] out_keep;
`ifdef FRAME_HDR_LEN_CHECK_EN
  logic [31:0] beat_cnt;
  logic trunc_inc;
`endif
  always_comb begin
    state_nxt = state;
    s.tready = 1'b0;
    out_valid = 1'b0;
    out_data = s.tdata;
    out_keep = s.tkeep;
    out_last = s.tlast;
    seq_inc = 1'b0;
`ifdef FRAME_HDR_LEN_CHECK_EN
    trunc_inc = 1'b0;
`endif
    case (state)
      IDLE: begin
        out_valid = s.tvalid;
        if (hdr_en) begin
          out_data = {SYNC_WORD, seq};
          out_keep = 4'hF;
          out_last = 1'b0;
          state_nxt = s.tvalid && load ? HDR1 : IDLE;
        end else begin
          // pass-through: this beat is forwarded directly from IDLE
          s.tready = load;
          state_nxt = s.tvalid && load && !s.tlast ? PAYLOAD : IDLE;
        end
      end
      HDR1: begin
        out_valid = 1'b1;
        out_data = 32'(ts_lat);
        out_keep = 4'hF;
        out_last = 1'b0;
        state_nxt = load ? PAYLOAD : HDR1;
      end
      PAYLOAD: begin
        s.tready = load;
        out_valid = s.tvalid;
        if (s.tvalid && load && s.tlast) begin
          state_nxt = IDLE;
          seq_inc = hdr_cur;
        end
`ifdef FRAME_HDR_LEN_CHECK_EN
        // overlong headed frame: close it here, the rest becomes a new frame
        else if (s.tvalid && load && hdr_cur && beat_cnt == max_len) begin
          out_last = 1'b1;
          state_nxt = IDLE;
          seq_inc = 1'b1;
          trunc_inc = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      seq <= '0;
      ts <= '0;
      ts_lat <= '0;
      hdr_cur <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_nxt;
      ts <= ts + TS_W'(1);
      seq <= seq + {15'd0, seq_inc};
      if (state == IDLE && s.tvalid && load) begin
        hdr_cur <= hdr_en;
        ts_lat <= ts;
      end
      if (m.tvalid && m.tready && m.tlast) frame_count <= frame_count + 32'd1;
    end
  end
`ifdef FRAME_HDR_LEN_CHECK_EN
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      beat_cnt <= '0;
      trunc_count <= '0;
    end else begin
      beat_cnt <= state != PAYLOAD ? '0 : s.tvalid && load ? beat_cnt + 32'd1 : beat_cnt;
      trunc_count <= trunc_inc && trunc_count != 16'hFFFF ? trunc_count + 16'd1 : trunc_count;
    end
  end
`else
  logic unused_max_len;
  assign unused_max_len = ^max_len;
  assign trunc_count = '0;
`endif
  axis_out_reg u_out (
    .clk(clk),
    .areset(areset),
    .in_valid(out_valid),
    .in_data(out_data),
    .in_keep(out_keep),
    .in_last(out_last),
    .load(load),
    .m(m)
  );
endmodule

// File: doc/frame_hdr_insert.md
# frame_hdr_insert

AXI4-Stream stage between the sample source (`stream_gen`) and the XDMA S2MM `stream_in` port of the block design. It prepends a two-word header to every frame, carrying a sync/sequence word and a timestamp, and then forwards the payload unchanged. Host software uses the header to detect dropped frames and to time-align captures. Optionally, it also enforces a maximum frame length.

## Interface
Parameters:
- `SYNC_WORD`, 16'hA5C3: upper half of header word 0.
- `TS_W`, 32: timestamp counter width; fixed at 32 in this revision.

Ports:
- `clk`  in  1  stream clock (axi_aclk domain).
- `areset`  in  1  asynchronous, active-high reset.
- `hdr_en`  in  1  1 = insert header; 0 = pure pass-through. Sampled only in IDLE.
- `max_len`  in  32  maximum payload beats minus 1. Used only when `FRAME_HDR_LEN_CHECK_EN` is defined.
- `s_tdata`/`s_tkeep`/`s_tlast`/`s_tvalid`  in  32/4/1/1  upstream stream.
- `s_tready`  out  1  upstream ready.
- `m_tdata`/`m_tkeep`/`m_tlast`/`m_tvalid`  out  32/4/1/1  downstream stream.
- `m_tready`  in  1  downstream ready.
- `frame_count`  out  32  completed frames (tlast accepted downstream side).
- `trunc_count`  out  16  frames truncated by the length check; constant 0 without the macro.

## Operation
- The output is a single register stage. Define `load = !m_tvalid || m_tready`.
- A free-running 32-bit timestamp counter `ts` increments every clock.
- FSM states: IDLE, HDR1, PAYLOAD.
  - IDLE:
    - `s_tready = 0` when `hdr_en`=1.
    - If `s_tvalid && load`, the block loads word 0 = {SYNC_WORD, seq[15:0]}, latches `ts` into `ts_lat`, and moves to HDR1.
    - If `hdr_en`=0, IDLE behaves as PAYLOAD for one beat: `s_tready = load`, data is forwarded, and the FSM enters PAYLOAD if tlast=0.
  - HDR1: `s_tready = 0`. On `load`, the block loads word 1 = `ts_lat` and moves to PAYLOAD.
  - PAYLOAD: `s_tready = load`. Each accepted beat is copied to the output register. When the accepted beat has tlast=1, the FSM returns to IDLE and `seq` increments.
- Header words always have tkeep=4'hF and tlast=0.
- `seq` is 16 bits and wraps from 16'hFFFF to 0. It increments only for frames that carried a header.
- `frame_count` increments when an output beat with tlast=1 is accepted (`m_tvalid && m_tready && m_tlast`). It wraps at 2^32.
- A change of `hdr_en` mid-frame takes effect at the next IDLE.

## Timing
- Reset values: `m_tvalid`=0, `m_tdata`=0, `m_tkeep`=0, `m_tlast`=0, `s_tready`=0, `seq`=0, `ts`=0, `frame_count`=0, `trunc_count`=0, state IDLE.
- Latency:
  - Header word 0 is valid on `m_*` 1 cycle after the first `s_tvalid` in IDLE.
  - Header word 1 follows 1 cycle later if `m_tready`=1.
  - The first payload beat is accepted at cycle 2 and appears at cycle 3.
- Throughput with `m_tready` held at 1: one beat per clock. A frame of N payload beats occupies N+2 output cycles.
- `s_tready` is combinational from `m_tready`, `m_tvalid` and the FSM state. There is no combinational path from `s_tvalid` to `s_tready`.
- Once `m_tvalid`=1, the block holds `m_tvalid` and `m_*` stable until `m_tready`=1 (AXI rule).
- Reset asserted mid-frame:
  - Everything clears immediately, and the partial frame is dropped from the output.
  - After release, upstream bytes still in flight are treated as a new frame.

## Configuration
- `FRAME_HDR_LEN_CHECK_EN` defined:
  - A 32-bit payload beat counter runs in PAYLOAD.
  - When the beat with index == `max_len` is accepted and `s_tlast`=0, it is forwarded with `m_tlast` forced to 1. `trunc_count` increments (saturating at 16'hFFFF), the FSM returns to IDLE, and `seq` increments.
  - The remaining upstream beats form a new, headed frame.
- Macro not defined: no counter is built, `max_len` is ignored, and `trunc_count` is tied to 0.

## Structure
- Shared package `frame_hdr_pkg` holds:
  - the state enum `frame_hdr_state_t` (IDLE, HDR1, PAYLOAD);
  - `FRAME_HDR_SYNC_DEFAULT` = 16'hA5C3;
  - `FRAME_HDR_WORDS` = 2.
- One sub-module, `axis_out_reg`: the output register holding tdata/tkeep/tlast/tvalid with the `load` logic. It is reusable by other stream stages.

## Test plan
- Reset, then a 4-beat frame (0x10..0x13, last on 0x13) with `m_tready`=1 -> output A5C3_0000, ts, 0x10, 0x11, 0x12, 0x13 (tlast on 0x13); `frame_count`=1.
- Three back-to-back 2-beat frames -> header sequence fields 0, 1, 2. Force `seq`=16'hFFFF -> next header A5C3_FFFF, then A5C3_0000.
- `m_tready` toggled 1-0-1-0 during header and payload -> no beat lost or duplicated; `m_*` stable while stalled; payload order preserved.
- `hdr_en`=0, 3-beat frame -> output identical to input with 1-cycle latency; `seq` unchanged. `hdr_en` toggled mid-frame -> takes effect only on the next frame.
- With `FRAME_HDR_LEN_CHECK_EN`, `max_len`=3, 6-beat frame -> first frame is header + 4 beats with tlast forced on beat 3, then header (seq+1) + 2 beats; `trunc_count`=1, `frame_count`=2.
- `areset` pulsed after 2 payload beats -> `m_tvalid`=0 immediately; the next frame starts with `seq`=0 and `ts` restarted.
